// File: rtl/reg_decr_nstage_valrdy_pkg.sv
// Shared definitions for the elastic N-stage decrementer.
//   MSG_NBITS   - width of a message byte
//   msg_t       - message type carried on every stage
//   MAX_NSTAGES - largest supported pipeline depth
//   msg_decr()  - modulo-256 decrement applied by each stage
package regdecr_pkg;

  localparam int MSG_NBITS   = 8;
  localparam int MAX_NSTAGES = 16;

  typedef logic [MSG_NBITS-1:0] msg_t;

  // Wraps 0x00 -> 0xFF.
  function automatic msg_t msg_decr(input msg_t m);
    return msg_t'(m - msg_t'(1));
  endfunction

endpackage

// File: rtl/reg_decr_nstage_valrdy_if.sv
// Valid/ready message channel.
// Handshake: a transfer happens on a rising clk edge where val && rdy are
// both high. While val is high and rdy is low, the master holds msg stable
// and keeps val asserted.
//   msg - message byte (master -> slave)
//   val - msg is valid (master -> slave)
//   rdy - slave accepts msg this cycle (slave -> master)
interface reg_decr_nstage_valrdy_if;
  import regdecr_pkg::*;

  msg_t msg;
  logic val;
  logic rdy;

  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/reg_decr_nstage_valrdy_stage.sv
// One elastic decrement stage: registers (in_msg - 1) with a valid bit.
//   clk, reset        - clock, synchronous active-high reset
//   in_msg/val/rdy    - upstream handshake (this stage is the consumer)
//   out_msg/val/rdy   - downstream handshake (this stage is the producer)
// in_rdy ripples combinationally from out_rdy, so a full chain moves
// forward as a whole in the cycle the consumer becomes ready.
module reg_decr_valrdy
  import regdecr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  msg_t in_msg,
  input  logic in_val,
  output logic in_rdy,
  output msg_t out_msg,
  output logic out_val,
  input  logic out_rdy
);

  logic val_q;
  msg_t msg_q;
  logic adv;
  logic fire_in;

  assign adv     = val_q && out_rdy;
  // Ready is forced high during reset, but fire_in is masked so nothing
  // offered during reset is captured.
  assign in_rdy  = reset || !val_q || out_rdy;
  assign fire_in = in_val && in_rdy && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= 1'b0;
      msg_q <= '0;
    end else if (fire_in) begin
      // A fill takes priority over a drain: simultaneous fire and adv
      // leaves the stage valid with the new message.
      val_q <= 1'b1;
      msg_q <= msg_decr(in_msg);
    end else if (adv) begin
      val_q <= 1'b0;
    end
  end

  assign out_msg = msg_q;
  assign out_val = val_q;

endmodule

// File: rtl/reg_decr_nstage_valrdy.sv
// Elastic N-stage registered decrementer: out_msg = in_msg - nstages
// (mod 256), latency nstages cycles, 1 msg/cycle, capacity nstages.
//   clk, reset - clock, synchronous active-high reset
//   in_if      - input channel (slave side: in_msg, in_val, in_rdy)
//   out_if     - output channel (master side: out_msg, out_val, out_rdy)
module reg_decr_nstage_valrdy
  import regdecr_pkg::*;
#(
  parameter int nstages = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  reg_decr_nstage_valrdy_if.slave         in_if,
  reg_decr_nstage_valrdy_if.master        out_if
);

  if (nstages < 1 || nstages > MAX_NSTAGES) begin : g_bad_nstages
    $error("reg_decr_nstage_valrdy: nstages must be in 1..16");
  end

  // Chain node k feeds stage k; node nstages is the block output.
  msg_t msg_c [nstages+1];
  logic val_c [nstages+1];
  logic rdy_c [nstages+1];

  assign msg_c[0]       = in_if.msg;
  assign val_c[0]       = in_if.val;
  assign in_if.rdy      = rdy_c[0];
  assign out_if.msg     = msg_c[nstages];
  assign out_if.val     = val_c[nstages];
  assign rdy_c[nstages] = out_if.rdy;

  for (genvar k = 0; k < nstages; k++) begin : g_stage
    reg_decr_valrdy u_stage (
      .clk     (clk),
      .reset   (reset),
      .in_msg  (msg_c[k]),
      .in_val  (val_c[k]),
      .in_rdy  (rdy_c[k]),
      .out_msg (msg_c[k+1]),
      .out_val (val_c[k+1]),
      .out_rdy (rdy_c[k+1])
    );
  end

endmodule

// File: tb/tb_reg_decr_nstage_valrdy.sv
// Bench for reg_decr_nstage_valrdy. Three instances (nstages = 2, 3, 4)
// share clk/reset; each has its own driver signals indexed by d = nstages-2.
// Inputs change and outputs are sampled on the falling edge.
module tb_reg_decr_nstage_valrdy;

  logic clk;
  logic reset;

  logic [7:0] in_msg  [3];
  logic       in_val  [3];
  logic       out_rdy [3];
  logic       in_rdy_w  [3];
  logic [7:0] out_msg_w [3];
  logic       out_val_w [3];

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_decr_nstage_valrdy_if in_if ();
    reg_decr_nstage_valrdy_if out_if ();

    assign in_if.msg     = in_msg[g];
    assign in_if.val     = in_val[g];
    assign in_rdy_w[g]   = in_if.rdy;
    assign out_msg_w[g]  = out_if.msg;
    assign out_val_w[g]  = out_if.val;
    assign out_if.rdy    = out_rdy[g];

    reg_decr_nstage_valrdy #(.nstages(g + 2)) dut (
      .clk    (clk),
      .reset  (reset),
      .in_if  (in_if.slave),
      .out_if (out_if.master)
    );
  end

  task automatic drive(input int d, input logic v, input logic [7:0] m, input logic r);
    in_val[d]  = v;
    in_msg[d]  = m;
    out_rdy[d] = r;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (out_val_w[d] !== 1'b0 || out_msg_w[d] !== 8'h00 || in_rdy_w[d] !== 1'b1) begin
          errors++;
          $display("FAIL reset_idle d=%0d c=%0d: val=%b msg=%h rdy=%b, required val=0 msg=00 rdy=1",
                   d, c, out_val_w[d], out_msg_w[d], in_rdy_w[d]);
        end
      end
    end
  endtask

  // nstages=2: 0x10,0x11,0x12 back to back -> 0x0E,0x0F,0x10 at c=2..4.
  task automatic test_stream;
    logic       ev;
    logic [7:0] em;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 4);
      em = 8'h0E + 8'(c - 2);
      checks++;
      if (out_val_w[0] !== ev || (ev && out_msg_w[0] !== em)) begin
        errors++;
        $display("FAIL stream c=%0d: val=%b msg=%h, required val=%b msg=%h",
                 c, out_val_w[0], out_msg_w[0], ev, em);
      end
      if (c < 3) drive(0, 1'b1, 8'h10 + 8'(c), 1'b1);
      else       drive(0, 1'b0, 8'h00, 1'b1);
      #1;
      if (c < 3) begin
        checks++;
        if (in_rdy_w[0] !== 1'b1) begin
          errors++;
          $display("FAIL stream_rdy c=%0d: in_rdy=%b, required 1", c, in_rdy_w[0]);
        end
      end
    end
  endtask

  // nstages=3: 0x00 -> 0xFD, 0x02 -> 0xFF.
  task automatic test_wrap;
    logic       ev;
    logic [7:0] em;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ev = (c == 3 || c == 4);
      em = (c == 3) ? 8'hFD : 8'hFF;
      checks++;
      if (out_val_w[1] !== ev || (ev && out_msg_w[1] !== em)) begin
        errors++;
        $display("FAIL wrap c=%0d: val=%b msg=%h, required val=%b msg=%h",
                 c, out_val_w[1], out_msg_w[1], ev, em);
      end
      if (c == 0)      drive(1, 1'b1, 8'h00, 1'b1);
      else if (c == 1) drive(1, 1'b1, 8'h02, 1'b1);
      else             drive(1, 1'b0, 8'h00, 1'b1);
    end
  endtask

  // nstages=2 with a stalled consumer: fills, stalls, then drains with the
  // held 0x52 accepted in the release cycle.
  task automatic test_back_pressure;
    logic       e_rdy   [8];
    logic       e_val   [8];
    logic [7:0] e_msg   [8];
    e_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    e_val = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_msg = '{8'h00, 8'h00, 8'h4E, 8'h4E, 8'h4E, 8'h4F, 8'h50, 8'h00};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_val_w[0] !== e_val[c] || (e_val[c] && out_msg_w[0] !== e_msg[c])) begin
        errors++;
        $display("FAIL back_pressure_out c=%0d: val=%b msg=%h, required val=%b msg=%h",
                 c, out_val_w[0], out_msg_w[0], e_val[c], e_msg[c]);
      end
      case (c)
        0:       drive(0, 1'b1, 8'h50, 1'b0);
        1:       drive(0, 1'b1, 8'h51, 1'b0);
        2, 3:    drive(0, 1'b1, 8'h52, 1'b0);
        4:       drive(0, 1'b1, 8'h52, 1'b1);
        default: drive(0, 1'b0, 8'h00, 1'b1);
      endcase
      #1;
      checks++;
      if (in_rdy_w[0] !== e_rdy[c]) begin
        errors++;
        $display("FAIL back_pressure_rdy c=%0d: in_rdy=%b, required %b", c, in_rdy_w[0], e_rdy[c]);
      end
    end
  endtask

  // nstages=4: random valid/ready, scoreboard out == in - 4 in order.
  task automatic test_random_stall;
    int   sent;
    int   cyc;
    logic pending;
    logic [7:0] exp;
    sent    = 0;
    cyc     = 0;
    pending = 1'b0;
    exp_q.delete();
    drive(2, 1'b0, 8'h00, 1'b0);
    while ((sent < 200 || exp_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!pending) begin
        if (sent < 200 && $urandom_range(0, 3) != 0) begin
          in_val[2] = 1'b1;
          in_msg[2] = 8'($urandom_range(0, 255));
        end else begin
          in_val[2] = 1'b0;
        end
      end
      out_rdy[2] = ($urandom_range(0, 3) != 0);
      #1;
      pending = in_val[2] && !in_rdy_w[2];
      if (in_val[2] && in_rdy_w[2]) begin
        exp_q.push_back(in_msg[2] - 8'd4);
        sent++;
      end
      if (out_val_w[2] && out_rdy[2]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra: got msg=%h, required no output", out_msg_w[2]);
        end else begin
          exp = exp_q.pop_front();
          if (out_msg_w[2] !== exp) begin
            errors++;
            $display("FAIL random_data: got msg=%h, required %h", out_msg_w[2], exp);
          end
        end
      end
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL random_timeout: sent=%0d pending=%0d, required 200 sent and 0 pending",
               sent, exp_q.size());
    end
    drive(2, 1'b0, 8'h00, 1'b1);
  endtask

  // nstages=3: two messages in flight, one-cycle reset with 0x99 offered;
  // nothing stale emerges and 0x20 comes out as 0x1D three cycles later.
  task automatic test_mid_reset;
    logic       ev;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ev = (c == 6);
      if (c >= 3) begin
        checks++;
        if (out_val_w[1] !== ev || (ev && out_msg_w[1] !== 8'h1D) || (c == 3 && out_msg_w[1] !== 8'h00)) begin
          errors++;
          $display("FAIL mid_reset c=%0d: val=%b msg=%h, required val=%b msg=%h",
                   c, out_val_w[1], out_msg_w[1], ev, (c == 3) ? 8'h00 : 8'h1D);
        end
      end
      reset = (c == 2);
      case (c)
        0:       drive(1, 1'b1, 8'h30, 1'b1);
        1:       drive(1, 1'b1, 8'h31, 1'b1);
        2:       drive(1, 1'b1, 8'h99, 1'b1);
        3:       drive(1, 1'b1, 8'h20, 1'b1);
        default: drive(1, 1'b0, 8'h00, 1'b1);
      endcase
      #1;
      if (c == 2) begin
        checks++;
        if (in_rdy_w[1] !== 1'b1) begin
          errors++;
          $display("FAIL mid_reset_rdy: in_rdy=%b during reset, required 1", in_rdy_w[1]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_wrap();
    test_back_pressure();
    test_random_stall();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
